// File: rtl/onehot_code_decoder_if.sv
// Handshake bundle for the streaming code-to-one-hot decoder: code input, one-hot output,
// and the sticky mask/err status with its clear.
interface onehot_code_decoder_if #(
    parameter int unsigned CODE_W = 3,
    parameter int unsigned OUT_W  = 8
);
    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              code_ready;
    logic              dout_valid;
    logic [OUT_W-1:0]  dout;
    logic              dout_ready;
    logic              mask_clr;
    logic [OUT_W-1:0]  mask;
    logic              err;

    modport master (
        output code_valid, code, dout_ready, mask_clr,
        input  code_ready, dout_valid, dout, mask, err
    );

    modport slave (
        input  code_valid, code, dout_ready, mask_clr,
        output code_ready, dout_valid, dout, mask, err
    );
endinterface

// File: rtl/onehot_code_decoder.sv
// Streaming binary-to-one-hot decoder with an output FIFO, sticky decoded-bit mask and
// sticky error flag for codes that have no output line.
module onehot_code_decoder #(
    parameter int unsigned CODE_W = 3,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_code_decoder_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic             err_q, err_d;

    logic             legal;
    logic [OUT_W-1:0] onehot;
    logic             accept;
    logic             push;
    logic             pop;

    // No pass-through when full: ready depends only on stored occupancy.
    assign bus.code_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign bus.dout_valid = !rst && (count_q != '0);
    assign bus.dout       = bus.dout_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.mask       = mask_q;
    assign bus.err        = err_q;

    assign legal  = 32'(bus.code) < OUT_W;
    assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << bus.code;
    assign accept = bus.code_valid && bus.code_ready;
    assign push   = accept && legal;
    assign pop    = bus.dout_valid && bus.dout_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mask_d   = mask_q;
        err_d    = err_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        // Clear first so a same-cycle accept lands on the cleared value.
        if (bus.mask_clr) begin
            mask_d = '0;
            err_d  = 1'b0;
        end
        if (accept) begin
            if (legal) mask_d = mask_d | onehot;
            else       err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= onehot;
    end
endmodule

// File: tb/tb_onehot_code_decoder.sv
// Directed table-driven bench for onehot_code_decoder at OUT_W=8 and OUT_W=6.
module tb_onehot_code_decoder;
    logic clk;
    logic rst8;
    logic rst6;
    int   checks;
    int   failures;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [2:0] code;
        logic       dr;
        logic       mclr;
        logic       e_cr;
        logic       e_dv;
        logic [7:0] e_dout;
        logic [7:0] e_mask;
        logic       e_err;
    } vec_t;

    vec_t tab8[$];
    vec_t tab6[$];

    onehot_code_decoder_if #(.CODE_W(3), .OUT_W(8)) b8 ();
    onehot_code_decoder_if #(.CODE_W(3), .OUT_W(6)) b6 ();

    onehot_code_decoder #(.CODE_W(3), .OUT_W(8), .DEPTH(2)) dut8 (
        .clk(clk), .rst(rst8), .bus(b8)
    );
    onehot_code_decoder #(.CODE_W(3), .OUT_W(6), .DEPTH(2)) dut6 (
        .clk(clk), .rst(rst6), .bus(b6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic cv, logic [2:0] code, logic dr, logic mclr,
                                logic ecr, logic edv, logic [7:0] edout, logic [7:0] emask,
                                logic eerr);
        vec_t v;
        v.rst = rst; v.cv = cv; v.code = code; v.dr = dr; v.mclr = mclr;
        v.e_cr = ecr; v.e_dv = edv; v.e_dout = edout; v.e_mask = emask; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply8(input vec_t v, input int idx);
        rst8 = v.rst; b8.code_valid = v.cv; b8.code = v.code;
        b8.dout_ready = v.dr; b8.mask_clr = v.mclr;
        #1;
        chk("dut8.code_ready", idx, 8'(b8.code_ready), 8'(v.e_cr));
        chk("dut8.dout_valid", idx, 8'(b8.dout_valid), 8'(v.e_dv));
        chk("dut8.dout",       idx, b8.dout,           v.e_dout);
        chk("dut8.mask",       idx, b8.mask,           v.e_mask);
        chk("dut8.err",        idx, 8'(b8.err),        8'(v.e_err));
        tick();
    endtask

    task automatic apply6(input vec_t v, input int idx);
        rst6 = v.rst; b6.code_valid = v.cv; b6.code = v.code;
        b6.dout_ready = v.dr; b6.mask_clr = v.mclr;
        #1;
        chk("dut6.code_ready", idx, 8'(b6.code_ready), 8'(v.e_cr));
        chk("dut6.dout_valid", idx, 8'(b6.dout_valid), 8'(v.e_dv));
        chk("dut6.dout",       idx, 8'(b6.dout),       v.e_dout);
        chk("dut6.mask",       idx, 8'(b6.mask),       v.e_mask);
        chk("dut6.err",        idx, 8'(b6.err),        8'(v.e_err));
        tick();
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;

        // rst cv code dr clr | cr dv dout mask err
        // Codes 0..7 streamed with dout_ready=1
        tab8.push_back(mk(0,1,0,1,0, 1,0,8'h00,8'h00,0));
        tab8.push_back(mk(0,1,1,1,0, 1,1,8'h01,8'h01,0));
        tab8.push_back(mk(0,1,2,1,0, 1,1,8'h02,8'h03,0));
        tab8.push_back(mk(0,1,3,1,0, 1,1,8'h04,8'h07,0));
        tab8.push_back(mk(0,1,4,1,0, 1,1,8'h08,8'h0F,0));
        tab8.push_back(mk(0,1,5,1,0, 1,1,8'h10,8'h1F,0));
        tab8.push_back(mk(0,1,6,1,0, 1,1,8'h20,8'h3F,0));
        tab8.push_back(mk(0,1,7,1,0, 1,1,8'h40,8'h7F,0));
        tab8.push_back(mk(0,0,0,1,0, 1,1,8'h80,8'hFF,0));
        tab8.push_back(mk(0,0,0,1,0, 1,0,8'h00,8'hFF,0));
        // Clear mask, rebuild 0F, then clear together with code 4
        tab8.push_back(mk(0,0,0,1,1, 1,0,8'h00,8'hFF,0));
        tab8.push_back(mk(0,1,0,1,0, 1,0,8'h00,8'h00,0));
        tab8.push_back(mk(0,1,1,1,0, 1,1,8'h01,8'h01,0));
        tab8.push_back(mk(0,1,2,1,0, 1,1,8'h02,8'h03,0));
        tab8.push_back(mk(0,1,3,1,0, 1,1,8'h04,8'h07,0));
        tab8.push_back(mk(0,1,4,1,1, 1,1,8'h08,8'h0F,0));
        tab8.push_back(mk(0,0,0,1,0, 1,1,8'h10,8'h10,0));
        tab8.push_back(mk(0,0,0,1,0, 1,0,8'h00,8'h10,0));
        // Backpressure: 3,5 fill the FIFO, 6 waits until a slot frees
        tab8.push_back(mk(0,1,3,0,0, 1,0,8'h00,8'h10,0));
        tab8.push_back(mk(0,1,5,0,0, 1,1,8'h08,8'h18,0));
        tab8.push_back(mk(0,1,6,0,0, 0,1,8'h08,8'h38,0));
        tab8.push_back(mk(0,1,6,1,0, 0,1,8'h08,8'h38,0));
        tab8.push_back(mk(0,1,6,1,0, 1,1,8'h20,8'h38,0));
        tab8.push_back(mk(0,0,0,1,0, 1,1,8'h40,8'h78,0));
        tab8.push_back(mk(0,0,0,1,0, 1,0,8'h00,8'h78,0));
        // Full FIFO with pop and a waiting code: no pass-through, order kept
        tab8.push_back(mk(0,1,1,0,0, 1,0,8'h00,8'h78,0));
        tab8.push_back(mk(0,1,2,0,0, 1,1,8'h02,8'h7A,0));
        tab8.push_back(mk(0,1,0,1,0, 0,1,8'h02,8'h7E,0));
        tab8.push_back(mk(0,1,0,1,0, 1,1,8'h04,8'h7E,0));
        tab8.push_back(mk(0,0,0,1,0, 1,1,8'h01,8'h7F,0));
        tab8.push_back(mk(0,0,0,1,0, 1,0,8'h00,8'h7F,0));
        // Reset with two words queued
        tab8.push_back(mk(0,1,3,0,0, 1,0,8'h00,8'h7F,0));
        tab8.push_back(mk(0,1,4,0,0, 1,1,8'h08,8'h7F,0));
        tab8.push_back(mk(1,1,5,1,0, 0,0,8'h00,8'h7F,0));
        tab8.push_back(mk(0,0,0,1,0, 1,0,8'h00,8'h00,0));

        // OUT_W=6: illegal code 7 then 2, clear variants, reset with data queued
        tab6.push_back(mk(0,1,7,1,0, 1,0,8'h00,8'h00,0));
        tab6.push_back(mk(0,1,2,1,0, 1,0,8'h00,8'h00,1));
        tab6.push_back(mk(0,0,0,1,0, 1,1,8'h04,8'h04,1));
        tab6.push_back(mk(0,1,6,1,1, 1,0,8'h00,8'h04,1));
        tab6.push_back(mk(0,0,0,1,1, 1,0,8'h00,8'h00,1));
        tab6.push_back(mk(0,1,5,0,0, 1,0,8'h00,8'h00,0));
        tab6.push_back(mk(0,0,0,0,0, 1,1,8'h20,8'h20,0));
        tab6.push_back(mk(1,0,0,0,0, 0,0,8'h00,8'h20,0));
        tab6.push_back(mk(0,0,0,0,0, 1,0,8'h00,8'h00,0));

        rst8 = 1'b1; rst6 = 1'b1;
        b8.code_valid = 1'b0; b8.code = '0; b8.dout_ready = 1'b0; b8.mask_clr = 1'b0;
        b6.code_valid = 1'b0; b6.code = '0; b6.dout_ready = 1'b0; b6.mask_clr = 1'b0;
        #1;
        chk("rst.code_ready", 0, 8'(b8.code_ready), 8'h00);
        chk("rst.dout_valid", 0, 8'(b8.dout_valid), 8'h00);
        tick();
        tick();
        rst8 = 1'b0; rst6 = 1'b0;
        #1;
        chk("post_rst.mask", 0, b8.mask,     8'h00);
        chk("post_rst.err",  0, 8'(b8.err),  8'h00);
        chk("post_rst.mask6", 0, 8'(b6.mask), 8'h00);

        foreach (tab8[i]) apply8(tab8[i], i);
        foreach (tab6[i]) apply6(tab6[i], i);

        // One-cycle latency into an empty FIFO, bounded wait
        b8.code_valid = 1'b1; b8.code = 3'd7; b8.dout_ready = 1'b0; b8.mask_clr = 1'b0;
        #1;
        chk("lat.code_ready", 0, 8'(b8.code_ready), 8'h01);
        tick();
        b8.code_valid = 1'b0;
        lat = 0;
        while (!b8.dout_valid && lat < 4) begin
            tick();
            lat++;
        end
        chk("lat.cycles", 0, 8'(lat), 8'h00);
        chk("lat.dout",   0, b8.dout, 8'h80);
        chk("lat.mask",   0, b8.mask, 8'h80);
        b8.dout_ready = 1'b1;
        tick();
        chk("lat.drained", 0, 8'(b8.dout_valid), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
